// File: rtl/cpu_run_controller.sv
// Run controller for the 4-bit CPU core: streams a program into the instruction
// RAM, then gates PC_EN for free-run or single-step execution and reports why it stopped.
module cpu_run_controller #(
  parameter int DEPTH      = 9,
  parameter int ADDR_W     = 4,
  parameter int WORD_W     = 18,
  parameter int CNT_W      = 8,
  parameter int MAX_CYCLES = 200
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_valid,
  input  logic [WORD_W-1:0] i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_halt_req,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [ADDR_W-1:0] o_ram_wa,
  output logic [WORD_W-1:0] o_ram_wd,
  output logic              o_ram_en,
  output logic              o_pc_en,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_done_reason,
  output logic [ADDR_W-1:0] o_prog_len,
  output logic [CNT_W-1:0]  o_cycle_count,
  output logic              o_err_overflow
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_prog_len;
  logic [ADDR_W-1:0] r_ram_wa;
  logic [WORD_W-1:0] r_ram_wd;
  logic              r_ram_en;
  logic              r_err;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_reason;

  logic              w_loading;
  logic              w_accept;
  logic              w_exec;
  logic              w_go;
  logic [ADDR_W-1:0] w_wa;
  logic [1:0]        w_stop;

  assign w_loading = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_accept  = i_load_valid && w_loading;
  assign w_exec    = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_wa      = (r_state == S_IDLE) ? {ADDR_W{1'b0}} : r_wptr;
  // a start that is actually taken (clear beats start)
  assign w_go      = ((r_state == S_READY) || (r_state == S_DONE)) && i_start && !i_clear;

  always_comb begin
    w_stop = 2'b00;
    if (i_halt_req) begin
      w_stop = 2'b11;
    end else if (i_pc >= r_prog_len) begin
      w_stop = 2'b01;
    end else if (r_count == BUDGET_LAST) begin
      w_stop = 2'b10;
    end else begin
      w_stop = 2'b00;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = i_load_last ? S_READY : S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_accept && (i_load_last || (w_wa == LAST_ADDR))) begin
          w_next = S_READY;
        end else begin
          w_next = S_LOAD;
        end
      end
      S_READY: begin
        if (i_clear) begin
          w_next = S_IDLE;
        end else if (i_start) begin
          w_next = S_RUN;
        end else if (i_step) begin
          w_next = S_STEP;
        end else begin
          w_next = S_READY;
        end
      end
      S_RUN: begin
        if (w_stop != 2'b00) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_STEP: begin
        if (w_stop != 2'b00) begin
          w_next = S_DONE;
        end else begin
          w_next = S_READY;
        end
      end
      S_DONE: begin
        if (i_clear) begin
          w_next = S_IDLE;
        end else if (i_start) begin
          w_next = S_RUN;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= {ADDR_W{1'b0}};
      r_prog_len <= {ADDR_W{1'b0}};
      r_ram_wa   <= {ADDR_W{1'b0}};
      r_ram_wd   <= {WORD_W{1'b0}};
      r_ram_en   <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= {CNT_W{1'b0}};
      r_reason   <= 2'b00;
    end else begin
      r_ram_en <= w_accept;
      if (w_accept) begin
        r_ram_wa   <= w_wa;
        r_ram_wd   <= i_load_data;
        r_wptr     <= w_wa + ADDR_W'(1);
        r_prog_len <= w_wa + ADDR_W'(1);
      end else if ((w_next == S_IDLE) && (r_state != S_IDLE)) begin
        r_prog_len <= {ADDR_W{1'b0}};
      end

      // a fresh program clears the flag; filling the last slot without load_last sets it
      if (w_accept && (r_state == S_IDLE)) begin
        r_err <= 1'b0;
      end else if (w_accept && !i_load_last && (w_wa == LAST_ADDR)) begin
        r_err <= 1'b1;
      end

      if (w_go) begin
        r_count <= {CNT_W{1'b0}};
      end else if (w_exec && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end

      if (w_exec && (w_stop != 2'b00)) begin
        r_reason <= w_stop;
      end else if ((r_state == S_DONE) && (w_next != S_DONE)) begin
        r_reason <= 2'b00;
      end
    end
  end

  assign o_load_ready   = w_loading;
  assign o_pc_en        = w_exec;
  assign o_busy         = (r_state == S_LOAD) || w_exec;
  assign o_done         = (r_state == S_DONE);
  assign o_ram_wa       = r_ram_wa;
  assign o_ram_wd       = r_ram_wd;
  assign o_ram_en       = r_ram_en;
  assign o_done_reason  = r_reason;
  assign o_prog_len     = r_prog_len;
  assign o_cycle_count  = r_count;
  assign o_err_overflow = r_err;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed scenarios plus random traffic, all
// checked every cycle against a program-queue model of the controller.
module tb_cpu_run_controller;
  localparam int DEPTH  = 9;
  localparam int ADDR_W = 4;
  localparam int WORD_W = 18;
  localparam int CNT_W  = 8;
  localparam int MAXC   = 5;

  localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2, M_RUN = 3, M_STEP = 4, M_DONE = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, load_valid, load_last, start, step, halt_req, clear;
  logic [WORD_W-1:0] load_data;
  logic [ADDR_W-1:0] pc;
  logic              o_load_ready, o_ram_en, o_pc_en, o_busy, o_done, o_err_overflow;
  logic [ADDR_W-1:0] o_ram_wa, o_prog_len;
  logic [WORD_W-1:0] o_ram_wd;
  logic [1:0]        o_done_reason;
  logic [CNT_W-1:0]  o_cycle_count;

  cpu_run_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W),
                       .MAX_CYCLES(MAXC)) dut (
    .i_clk(clk), .i_rst(rst), .i_load_valid(load_valid), .i_load_data(load_data),
    .i_load_last(load_last), .o_load_ready(o_load_ready), .i_start(start), .i_step(step),
    .i_halt_req(halt_req), .i_clear(clear), .i_pc(pc), .o_ram_wa(o_ram_wa),
    .o_ram_wd(o_ram_wd), .o_ram_en(o_ram_en), .o_pc_en(o_pc_en), .o_busy(o_busy),
    .o_done(o_done), .o_done_reason(o_done_reason), .o_prog_len(o_prog_len),
    .o_cycle_count(o_cycle_count), .o_err_overflow(o_err_overflow)
  );

  int checks = 0;
  int errors = 0;

  // model: the loaded program is a queue, its size is prog_len
  int                mode = M_IDLE;
  logic [WORD_W-1:0] prog[$];
  bit                e_we = 1'b0;
  int                e_wa = 0;
  logic [WORD_W-1:0] e_wd = '0;
  int                e_count = 0;
  int                e_reason = 0;
  bit                e_err = 1'b0;
  bit                live = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int  r;
    bit  acc;
    live = 1'b1;
    e_we = 1'b0;
    if (rst) begin
      mode = M_IDLE; prog.delete(); e_count = 0; e_reason = 0; e_err = 1'b0;
      return;
    end
    acc = load_valid && (mode == M_IDLE || mode == M_LOAD);
    case (mode)
      M_IDLE, M_LOAD: if (acc) begin
        if (mode == M_IDLE) begin prog.delete(); e_err = 1'b0; end
        e_we = 1'b1; e_wa = prog.size(); e_wd = load_data;
        prog.push_back(load_data);
        if (load_last) mode = M_READY;
        else if (prog.size() == DEPTH) begin mode = M_READY; e_err = 1'b1; end
        else mode = M_LOAD;
      end
      M_READY: begin
        if (clear) begin prog.delete(); mode = M_IDLE; end
        else if (start) begin e_count = 0; e_reason = 0; mode = M_RUN; end
        else if (step) mode = M_STEP;
      end
      M_RUN, M_STEP: begin
        r = halt_req ? 3 : (int'(pc) >= prog.size()) ? 1 : (e_count == MAXC - 1) ? 2 : 0;
        if (e_count < 255) e_count++;
        if (r != 0) begin e_reason = r; mode = M_DONE; end
        else if (mode == M_STEP) mode = M_READY;
      end
      M_DONE: begin
        if (clear) begin prog.delete(); e_reason = 0; mode = M_IDLE; end
        else if (start) begin e_count = 0; e_reason = 0; mode = M_RUN; end
      end
      default: mode = M_IDLE;
    endcase
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("ram_en", 32'(o_ram_en), 32'(e_we));
      if (e_we) begin
        chk("ram_wa", 32'(o_ram_wa), 32'(e_wa));
        chk("ram_wd", 32'(o_ram_wd), 32'(e_wd));
      end
      chk("pc_en", 32'(o_pc_en), 32'(mode == M_RUN || mode == M_STEP));
      chk("busy", 32'(o_busy), 32'(mode == M_LOAD || mode == M_RUN || mode == M_STEP));
      chk("done", 32'(o_done), 32'(mode == M_DONE));
      chk("load_ready", 32'(o_load_ready), 32'(mode == M_IDLE || mode == M_LOAD));
      chk("done_reason", 32'(o_done_reason), 32'(e_reason));
      chk("prog_len", 32'(o_prog_len), 32'(prog.size()));
      chk("cycle_count", 32'(o_cycle_count), 32'(e_count));
      chk("err_overflow", 32'(o_err_overflow), 32'(e_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic load_word(input logic [WORD_W-1:0] d, input bit last);
    repeat ($urandom_range(0, 1)) cyc();
    load_valid = 1'b1; load_data = d; load_last = last;
    cyc();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  // drives pc as the RUN-cycle index (or holds 0) until done, bounded
  task automatic run_until_done(input bit hold0, output int n);
    n = 0;
    for (int k = 0; k < 40 && !o_done; k++) begin
      if (o_pc_en) begin
        pc = hold0 ? '0 : ADDR_W'(n);
        n++;
      end
      cyc();
    end
    chk("run_reached_done", 32'(o_done), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    start = 1'b0; step = 1'b0; halt_req = 1'b0; clear = 1'b0; pc = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_load_ready", 32'(o_load_ready), 32'd1);
    chk("rst_prog_len", 32'(o_prog_len), 32'd0);

    // three-word load
    load_word(18'h0A001, 1'b0);
    load_word(18'h12345, 1'b0);
    load_word(18'h20000, 1'b1);
    chk("load3_en", 32'(o_ram_en), 32'd1);
    chk("load3_wa", 32'(o_ram_wa), 32'd2);
    chk("load3_wd", 32'(o_ram_wd), 32'h20000);
    chk("load3_len", 32'(o_prog_len), 32'd3);
    chk("load3_ready", 32'(o_load_ready), 32'd0);

    // run to end of program
    pc = '0;
    pulse_start();
    run_until_done(1'b0, n);
    chk("end_pc_en_cycles", 32'(n), 32'd4);
    chk("end_reason", 32'(o_done_reason), 32'd1);
    chk("end_count", 32'(o_cycle_count), 32'd4);

    // overflow load
    clear = 1'b1; cyc(); clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) load_word(WORD_W'($urandom), 1'b0);
    chk("ovf_err", 32'(o_err_overflow), 32'd1);
    chk("ovf_len", 32'(o_prog_len), 32'd9);
    load_valid = 1'b1; load_data = 18'h3FFFF;
    cyc(); cyc();
    chk("ovf_no_write", 32'(o_ram_en), 32'd0);
    load_valid = 1'b0;

    // budget, then rerun from DONE
    pc = '0;
    pulse_start();
    run_until_done(1'b1, n);
    chk("budget_cycles", 32'(n), 32'd5);
    chk("budget_reason", 32'(o_done_reason), 32'd2);
    pulse_start();
    chk("rerun_count_cleared", 32'(o_cycle_count), 32'd0);
    run_until_done(1'b1, n);
    chk("rerun_cycles", 32'(n), 32'd5);

    // single step
    clear = 1'b1; cyc(); clear = 1'b0;
    load_word(18'h00001, 1'b0);
    load_word(18'h00002, 1'b0);
    load_word(18'h00003, 1'b1);
    pc = '0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; cyc(); step = 1'b0;
      chk("step_pc_en_high", 32'(o_pc_en), 32'd1);
      cyc();
      chk("step_pc_en_low", 32'(o_pc_en), 32'd0);
      chk("step_not_done", 32'(o_done), 32'd0);
    end

    // halt outranks end-of-program
    halt_req = 1'b1; pc = 4'd5;
    pulse_start();
    cyc();
    halt_req = 1'b0;
    chk("halt_done", 32'(o_done), 32'd1);
    chk("halt_reason", 32'(o_done_reason), 32'd3);

    // clear beats start
    clear = 1'b1; start = 1'b1; cyc(); clear = 1'b0; start = 1'b0;
    chk("clear_wins_ready", 32'(o_load_ready), 32'd1);
    chk("clear_wins_pc_en", 32'(o_pc_en), 32'd0);

    // reset mid-load
    load_word(18'h11111, 1'b0);
    load_word(18'h22222, 1'b0);
    load_valid = 1'b1; load_data = 18'h33333; rst = 1'b1;
    cyc();
    rst = 1'b0; load_valid = 1'b0;
    chk("rst_mid_ram_en", 32'(o_ram_en), 32'd0);
    chk("rst_mid_len", 32'(o_prog_len), 32'd0);
    chk("rst_mid_ready", 32'(o_load_ready), 32'd1);
    load_word(18'h0BEEF, 1'b1);
    chk("reload_wa", 32'(o_ram_wa), 32'd0);
    chk("reload_en", 32'(o_ram_en), 32'd1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      load_valid = ($urandom_range(0, 1) == 1);
      load_data  = WORD_W'($urandom);
      load_last  = ($urandom_range(0, 4) == 0);
      start      = ($urandom_range(0, 14) == 0);
      step       = ($urandom_range(0, 9) == 0);
      clear      = ($urandom_range(0, 29) == 0);
      halt_req   = ($urandom_range(0, 24) == 0);
      pc         = ADDR_W'($urandom_range(0, 10));
      cyc();
    end
    rst = 1'b0; load_valid = 1'b0; start = 1'b0; step = 1'b0; clear = 1'b0; halt_req = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Sequencer in front of the 4-bit CPU core. It accepts a stream of 18-bit instruction words over a valid/ready handshake and writes them into the 9-entry instruction RAM through the core's RAM write port. It then releases the core by gating PC_EN, either free-running or single-stepping. Execution stops on end of program, an exhausted cycle budget, or an external halt, and the stop reason is reported.

Parameters:
DEPTH, 9, number of instruction RAM entries; writable addresses are 0..DEPTH-1.
ADDR_W, 4, RAM address and PC width.
WORD_W, 18, instruction word width.
CNT_W, 8, cycle counter width.
MAX_CYCLES, 200, run budget in pc_en-high cycles; must be at most 2^CNT_W-1.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
load_valid  in  1  instruction word offered.
load_data  in  WORD_W  instruction word.
load_last  in  1  offered word is the final program word.
load_ready  out  1  controller can accept a word.
start  in  1  one-cycle pulse: free-run program.
step  in  1  one-cycle pulse: execute one instruction.
halt_req  in  1  external stop request.
clear  in  1  discard the loaded program and return to IDLE.
pc  in  ADDR_W  current core PC, used for end-of-program detection.
ram_wa  out  ADDR_W  RAM write address (drives RAM_WA).
ram_wd  out  WORD_W  RAM write data (drives RAM_WD).
ram_en  out  1  RAM write enable (drives RAM_EN).
pc_en  out  1  core execution enable (drives PC_EN).
busy  out  1  high in LOAD, RUN and STEP.
done  out  1  high in DONE.
done_reason  out  2  00 none, 01 end of program, 10 budget exhausted, 11 halted.
prog_len  out  ADDR_W  number of words loaded.
cycle_count  out  CNT_W  pc_en-high cycles since the last start.
err_overflow  out  1  sticky flag: program filled the RAM without load_last.

Behaviour:
- Reset, synchronous and active-high, sets state=IDLE and drives every output to 0. The only exception is load_ready, which is 1 in IDLE. A reset in any state aborts the operation: a partially loaded program is discarded, and ram_en and pc_en are low from the next cycle.
- State register: IDLE, LOAD, READY, RUN, STEP, DONE.
- Handshake: a word is accepted when load_valid && load_ready. load_ready is 1 in IDLE and LOAD, and 0 in all other states.
- Write latency is 1 cycle. On the cycle after an accept, ram_en=1, ram_wa=write pointer and ram_wd=the accepted word, for exactly one cycle. All three are registered; ram_en is 0 otherwise.
- IDLE: the first accept writes address 0, clears err_overflow and moves to LOAD, or directly to READY if load_last is set.
- LOAD: each accept increments the write pointer, and prog_len tracks the number of words written.
  - load_last accepted: go to READY.
  - Accept at address DEPTH-1 without load_last: go to READY and set err_overflow. prog_len=DEPTH.
- Words offered outside IDLE/LOAD are ignored, with no RAM write.
- READY:
  - start: clear cycle_count and done_reason, go to RUN.
  - step (without start): go to STEP.
  - start has priority over step when both occur in the same cycle.
  - clear: go to IDLE with prog_len=0.
- RUN: pc_en=1 in every RUN cycle. cycle_count increments once per cycle and saturates at all-ones. Stop conditions are evaluated each RUN cycle, highest priority first:
  - halt_req: reason 11.
  - pc >= prog_len: reason 01.
  - cycle_count == MAX_CYCLES-1 on this cycle: reason 10.
  - Any stop condition moves to DONE at the next edge; pc_en is 0 in DONE.
- STEP lasts exactly one cycle with pc_en=1, and cycle_count increments. The same stop checks apply: if any fires, go to DONE; otherwise return to READY.
- DONE: done=1, and done_reason holds until leaving DONE.
  - start: rerun, going to RUN with cycle_count cleared.
  - clear: go to IDLE.
  - step and load_valid are ignored.
- clear and start in the same cycle: clear wins.
- pc_en is a combinational decode of state only (RUN or STEP), so it is glitch-free relative to clk.
- busy = state in {LOAD, RUN, STEP}.

Test Plan:
- Load: words 0x0A001, 0x12345, 0x20000 with load_last on the third → three ram_en pulses at addresses 0,1,2 with matching data, each 1 cycle after its accept; prog_len=3; state READY; load_ready=0.
- Overflow: 9 words, none with load_last → writes at 0..8, err_overflow=1, prog_len=9; a 10th load_valid gets no accept and no write.
- Run to end: after loading 3 words, start; bench drives pc 0,1,2,3 → pc_en high 4 cycles, done=1, done_reason=01, cycle_count=4.
- Budget: MAX_CYCLES=5, prog_len=9, bench holds pc=0 → pc_en high exactly 5 cycles, done_reason=10; a second start reruns with cycle_count cleared.
- Step, halt and priority: step three times → three single-cycle pc_en pulses returning to READY. Then start with halt_req asserted together with pc>=prog_len → done_reason=11.
- Reset mid-load: rst asserted after 2 accepts → next cycle ram_en=0, prog_len=0, load_ready=1, state IDLE. A fresh load then writes again from address 0.
